// File: rtl/vec_mag_pkg.sv
// Shared types and width helpers for the sequential vector-magnitude unit.
package vec_mag_pkg;

   // Control states of the magnitude sequencer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQ   = 2'd1,
      ROOT = 2'd2,
      DONE = 2'd3
   } state_t;

   // Result width for W-bit operands: sqrt(2 * (2^W - 1)^2) < 2^(W+1).
   function automatic int rw_of(input int w);
      return w + 1;
   endfunction

   // Sum-of-squares width: two W-bit squares added never exceed 2W+1 bits.
   function automatic int sw_of(input int w);
      return 2 * w + 1;
   endfunction

   // Root width produced from a radicand of radw bits (radicand padded to even width).
   function automatic int root_w_of(input int radw);
      return (radw + 1) / 2;
   endfunction

   // Counter width needed to count root bits down to zero.
   function automatic int cnt_w_of(input int rw);
      return (rw > 1) ? $clog2(rw) : 1;
   endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Restoring shift/subtract integer square root, one result bit per enabled
// clock, MSB first. No multiplier in the loop. The root/rem outputs carry the
// values produced by the current step, so they are the final result in the
// cycle where done is high.
module isqrt_seq
   import vec_mag_pkg::*;
#(
   parameter int RADW = 17
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ena,
   input  logic                           start,
   input  logic [RADW-1:0]                radicand,
   output logic [root_w_of(RADW)-1:0]     root,
   output logic [root_w_of(RADW)+1:0]     rem,
   output logic                           done
);

   localparam int RTW  = root_w_of(RADW);
   localparam int PW   = 2 * RTW;       // radicand zero-extended to an even width
   localparam int REMW = RTW + 2;       // holds rem<<2 | pair before any subtract
   localparam int CW   = cnt_w_of(RTW);

   logic [PW-1:0]   sum_reg;
   logic [REMW-1:0] rem_reg;
   logic [RTW-1:0]  root_reg;
   logic [CW-1:0]   cnt_reg;
   logic            active_reg;

   logic [REMW-1:0] cur;
   logic [REMW-1:0] trial_sub;
   logic [REMW-1:0] diff;
   logic            ge;
   logic [REMW-1:0] rem_step;
   logic [RTW-1:0]  root_step;

   // One digit of the recurrence: bring down the next pair, try subtracting 4*root+1.
   // The remainder before the last step is at most 2*root < 2^RTW, so dropping its
   // top two bits in the shift loses nothing.
   always_comb begin
      cur       = {rem_reg[REMW-3:0], sum_reg[PW-1 -: 2]};
      trial_sub = {root_reg, 2'b01};
      ge        = (cur >= trial_sub);
      diff      = cur - trial_sub;
      rem_step  = ge ? diff : cur;
      root_step = {root_reg[RTW-2:0], ge};
   end

   assign root = root_step;
   assign rem  = rem_step;
   assign done = active_reg && (cnt_reg == '0);

   // Load the radicand on start, then step once per enabled edge until the count expires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_reg    <= '0;
         rem_reg    <= '0;
         root_reg   <= '0;
         cnt_reg    <= '0;
         active_reg <= 1'b0;
      end else if (ena) begin
         if (start) begin
            sum_reg    <= PW'(radicand);
            rem_reg    <= '0;
            root_reg   <= '0;
            cnt_reg    <= CW'(RTW - 1);
            active_reg <= 1'b1;
         end else if (active_reg) begin
            sum_reg  <= {sum_reg[PW-3:0], 2'b00};
            rem_reg  <= rem_step;
            root_reg <= root_step;
            if (cnt_reg == '0) begin
               active_reg <= 1'b0;
            end else begin
               cnt_reg <= cnt_reg - CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/vec_mag_seq.sv
// Sequential Euclidean magnitude: mag = floor(sqrt(x^2 + y^2)) with valid/ready
// handshakes and an exactness flag. ena freezes the whole block when low.
// Optional build macro VEC_MAG_ROUND_EN rounds the result to nearest instead of
// truncating; exact always reflects the unrounded remainder.
module vec_mag_seq
   import vec_mag_pkg::*;
#(
   parameter int W  = 8,
   parameter int RW = rw_of(W),
   parameter int SW = sw_of(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  x,
   input  logic [W-1:0]  y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] mag,
   output logic          exact,
   output logic          busy
);

   state_t state_reg, state_next;

   logic [W-1:0]    x_reg, y_reg;
   logic [RW-1:0]   mag_reg;
   logic            exact_reg;

   logic [2*W-1:0]  x_ext, y_ext, x_sq, y_sq;
   logic [SW-1:0]   sum_sq;

   logic            root_start;
   logic            root_done;
   logic [RW-1:0]   root_res;
   logic [RW+1:0]   rem_res;
   logic [RW-1:0]   mag_fin;

   // Squares are formed once from the captured operands, outside the root loop.
   assign x_ext  = {{W{1'b0}}, x_reg};
   assign y_ext  = {{W{1'b0}}, y_reg};
   assign x_sq   = x_ext * x_ext;
   assign y_sq   = y_ext * y_ext;
   assign sum_sq = {1'b0, x_sq} + {1'b0, y_sq};

   isqrt_seq #(
      .RADW (SW)
   ) u_isqrt (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .start    (root_start),
      .radicand (sum_sq),
      .root     (root_res),
      .rem      (rem_res),
      .done     (root_done)
   );

`ifdef VEC_MAG_ROUND_EN
   // Round to nearest: sqrt(s) >= r + 0.5 exactly when rem > r; ties cannot occur.
   assign mag_fin = (rem_res > {2'b00, root_res}) ? (root_res + RW'(1)) : root_res;
`else
   assign mag_fin = root_res;
`endif

   // State register; frozen while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else if (ena) begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake outputs; DONE never accepts input in the same cycle.
   always_comb begin
      state_next = state_reg;
      root_start = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_next = SQ;
         end
         SQ: begin
            root_start = 1'b1;
            state_next = ROOT;
         end
         ROOT: begin
            if (root_done) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture operands on the accepting edge so later input changes are harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg <= '0;
         y_reg <= '0;
      end else if (ena && state_reg == IDLE && in_valid) begin
         x_reg <= x;
         y_reg <= y;
      end
   end

   // Result registers load on entry to DONE and hold until the next result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_reg   <= '0;
         exact_reg <= 1'b0;
      end else if (ena && state_reg == ROOT && root_done) begin
         mag_reg   <= mag_fin;
         exact_reg <= (rem_res == '0);
      end
   end

   assign mag   = mag_reg;
   assign exact = exact_reg;

endmodule
